counter_seq_ctrl: RTL and testbench

Sequencer for the loadable up/down counter pair on the counter interface. On a start request it clears both counters and loads their preset values (up = 5, down = 10). It then lets them free-run until the up counter reaches a programmed target value, or until a cycle budget expires. It reports the elapsed run length and sits between the test/control logic and the counter datapath, driving that datapath's `reset` and `load` inputs.

---
 rtl/counter_seq_pkg.sv | 19 +
 rtl/counter_seq_ctrl_timer.sv | 34 +++
 rtl/counter_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: shared state encoding and counter preset values for the
// counter sequencer and its testbench.
package counter_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Values the counter datapath takes on its load and reset inputs.
  localparam int UP_LOAD_VAL    = 5;
  localparam int DOWN_LOAD_VAL  = 10;
  localparam int UP_RESET_VAL   = 0;
  localparam int DOWN_RESET_VAL = 15;

endpackage

// File: rtl/counter_seq_ctrl_timer.sv
// cnt_seq_timer: RW-bit run-length counter. Cleared on request, increments
// while enabled, and saturates at MAX_CYCLES-1 so it can never wrap.
module cnt_seq_timer #(
  parameter int RW         = 8,
  parameter int MAX_CYCLES = 200
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [RW-1:0] o_cnt,
  output logic          o_at_budget
);

  localparam logic [RW-1:0] LAST = RW'(MAX_CYCLES - 1);

  logic [RW-1:0] r_cnt;
  logic          w_at_budget;

  assign w_at_budget = (r_cnt == LAST);

  // Run counter: clear has priority, increment stops at the last budget slot.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_budget) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt       = r_cnt;
  assign o_at_budget = w_at_budget;

endmodule

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: sequences the up/down counter pair (clear, load, free-run)
// until the up counter hits a captured target or the run budget expires.
// Optional crossing detector enabled by defining COUNTER_SEQ_CROSS_DETECT_EN.
//
// Handshake: start is a level request honoured only in IDLE; abort cancels
// any non-IDLE, non-DONE state and outranks start. done/timeout are
// single-cycle pulses; all outputs are registered from the next state.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int CW         = 4,
  parameter int RW         = 8,
  parameter int MAX_CYCLES = 200
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] target,
  input  logic [CW-1:0] up_counter,
  input  logic [CW-1:0] down_counter,
  output logic          cnt_reset,
  output logic          cnt_load,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [RW-1:0] run_cycles,
  output logic          cross_seen,
  output logic [RW-1:0] cross_at
);

  state_e        r_state;
  state_e        w_next;
  logic [CW-1:0] r_target;
  logic          w_accept;
  logic          w_match;
  logic          w_set_run;
  logic [RW-1:0] w_run_val;
  logic          w_timeout;
  logic [RW-1:0] w_run_cnt;
  logic          w_at_budget;

  assign w_accept = (r_state == ST_IDLE) && start && !abort;
  assign w_match  = (up_counter == r_target);

  cnt_seq_timer #(
    .RW         (RW),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_timer (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_clr       (r_state == ST_LOAD),
    .i_inc       (r_state == ST_RUN),
    .o_cnt       (w_run_cnt),
    .o_at_budget (w_at_budget)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus the run-length result latched on entry to DONE.
  always_comb begin
    w_next    = r_state;
    w_set_run = 1'b0;
    w_run_val = '0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_CLEAR;
      ST_CLEAR: w_next = abort ? ST_IDLE : ST_LOAD;
      ST_LOAD:  w_next = abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else if (w_match) begin
          w_next    = ST_DONE;
          w_set_run = 1'b1;
          w_run_val = w_run_cnt;
        end else if (w_at_budget) begin
          w_next    = ST_DONE;
          w_set_run = 1'b1;
          w_run_val = RW'(MAX_CYCLES);
          w_timeout = 1'b1;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Registered outputs decoded from the next state; target captured on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reset  <= 1'b0;
      cnt_load   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      run_cycles <= '0;
      r_target   <= '0;
    end else begin
      cnt_reset <= (w_next == ST_CLEAR);
      cnt_load  <= (w_next == ST_LOAD);
      busy      <= (w_next != ST_IDLE);
      done      <= (w_next == ST_DONE);
      timeout   <= w_timeout;
      if (w_set_run) run_cycles <= w_run_val;
      if (w_accept)  r_target   <= target;
    end
  end

`ifdef COUNTER_SEQ_CROSS_DETECT_EN
  logic          r_cross_seen;
  logic [RW-1:0] r_cross_at;

  // First RUN sample with up > down is recorded; cleared on an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cross_seen <= 1'b0;
      r_cross_at   <= '0;
    end else if (w_accept) begin
      r_cross_seen <= 1'b0;
      r_cross_at   <= '0;
    end else if ((r_state == ST_RUN) && !r_cross_seen && (up_counter > down_counter)) begin
      r_cross_seen <= 1'b1;
      r_cross_at   <= w_run_cnt;
    end
  end

  assign cross_seen = r_cross_seen;
  assign cross_at   = r_cross_at;
`else
  // The down counter only feeds the crossing comparator.
  logic w_unused_down;
  assign w_unused_down = ^down_counter;
  assign cross_seen    = 1'b0;
  assign cross_at      = '0;
`endif

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: directed bench for counter_seq_ctrl. Two instances
// (default budget and MAX_CYCLES=4), each driving a behavioural model of the
// loadable up/down counter pair.
module tb_counter_seq_ctrl;
  import counter_seq_pkg::*;

  localparam int CW = 4;
  localparam int RW = 8;

  // Clock/reset block.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          abort = 1'b0;
  logic [CW-1:0] target = '0;
  logic          start_a = 1'b0;
  logic          start_b = 1'b0;

  logic [CW-1:0] up_a, dn_a, up_b, dn_b;
  logic          cnt_reset_a, cnt_load_a, busy_a, done_a, timeout_a, cross_seen_a;
  logic [RW-1:0] run_cycles_a, cross_at_a;
  logic          cnt_reset_b, cnt_load_b, busy_b, done_b, timeout_b, cross_seen_b;
  logic [RW-1:0] run_cycles_b, cross_at_b;

  int n_chk = 0;
  int n_err = 0;
  int n;

`ifdef COUNTER_SEQ_CROSS_DETECT_EN
  localparam bit XD = 1'b1;
`else
  localparam bit XD = 1'b0;
`endif

  counter_seq_ctrl #(.CW(CW), .RW(RW), .MAX_CYCLES(200)) dut (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort), .target(target),
    .up_counter(up_a), .down_counter(dn_a),
    .cnt_reset(cnt_reset_a), .cnt_load(cnt_load_a), .busy(busy_a), .done(done_a),
    .timeout(timeout_a), .run_cycles(run_cycles_a),
    .cross_seen(cross_seen_a), .cross_at(cross_at_a)
  );

  counter_seq_ctrl #(.CW(CW), .RW(RW), .MAX_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort), .target(target),
    .up_counter(up_b), .down_counter(dn_b),
    .cnt_reset(cnt_reset_b), .cnt_load(cnt_load_b), .busy(busy_b), .done(done_b),
    .timeout(timeout_b), .run_cycles(run_cycles_b),
    .cross_seen(cross_seen_b), .cross_at(cross_at_b)
  );

  // Counter pair models: reset beats load, otherwise up counts up, down counts down.
  always @(posedge clk) begin
    if (cnt_reset_a) begin
      up_a <= CW'(UP_RESET_VAL);  dn_a <= CW'(DOWN_RESET_VAL);
    end else if (cnt_load_a) begin
      up_a <= CW'(UP_LOAD_VAL);   dn_a <= CW'(DOWN_LOAD_VAL);
    end else begin
      up_a <= up_a + 1'b1;        dn_a <= dn_a - 1'b1;
    end
    if (cnt_reset_b) begin
      up_b <= CW'(UP_RESET_VAL);  dn_b <= CW'(DOWN_RESET_VAL);
    end else if (cnt_load_b) begin
      up_b <= CW'(UP_LOAD_VAL);   dn_b <= CW'(DOWN_LOAD_VAL);
    end else begin
      up_b <= up_b + 1'b1;        dn_b <= dn_b - 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits for done on instance A, returning the number of edges taken.
  task automatic wait_done_a(output int cnt);
    cnt = 0;
    while (done_a !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    up_a = '0; dn_a = '0; up_b = '0; dn_b = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_cnt_reset", cnt_reset_a, 0);
    chk("rst_cnt_load", cnt_load_a, 0);
    chk("rst_run_cycles", run_cycles_a, 0);

    // Target 8: match at sample 3, crossing 8/7 on that same sample.
    target = 4'd8; start_a = 1'b1;
    tick();                               // E0
    start_a = 1'b0;
    chk("t8_clear_rst", cnt_reset_a, 1);
    chk("t8_clear_load", cnt_load_a, 0);
    chk("t8_clear_busy", busy_a, 1);
    tick();                               // E1
    chk("t8_load_rst", cnt_reset_a, 0);
    chk("t8_load_load", cnt_load_a, 1);
    tick();                               // E2
    chk("t8_run_load", cnt_load_a, 0);
    chk("t8_run_rst", cnt_reset_a, 0);
    wait_done_a(n);
    chk("t8_edges_to_done", n, 4);
    chk("t8_timeout", timeout_a, 0);
    chk("t8_run_cycles", run_cycles_a, 3);
    chk("t8_busy_in_done", busy_a, 1);
    chk("t8_cross_seen", cross_seen_a, XD ? 1 : 0);
    chk("t8_cross_at", cross_at_a, XD ? 3 : 0);
    tick();
    chk("t8_done_pulse", done_a, 0);
    chk("t8_idle_busy", busy_a, 0);
    chk("t8_hold_run_cycles", run_cycles_a, 3);

    // Target 5: minimum latency, 4 edges counting the accepting edge.
    target = 4'd5; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done_a(n);
    chk("t5_edges_to_done", n + 1, 4);
    chk("t5_run_cycles", run_cycles_a, 0);
    chk("t5_cross_cleared", cross_seen_a, 0);

    // Start raised during DONE is ignored; accepted one edge later in IDLE.
    target = 4'd2; start_a = 1'b1;
    tick();
    chk("b2b_ignored_busy", busy_a, 0);
    chk("b2b_ignored_rst", cnt_reset_a, 0);
    tick();
    start_a = 1'b0;
    chk("b2b_accept_rst", cnt_reset_a, 1);
    tick(); tick();
    // Target 2 needs the up counter to wrap 15 -> 0: sample 13.
    wait_done_a(n);
    chk("t2_edges_to_done", n, 14);
    chk("t2_run_cycles", run_cycles_a, 13);
    chk("t2_timeout", timeout_a, 0);
    tick();

    // Abort at the sample-2 edge: back to IDLE, no done, run_cycles kept.
    target = 4'd9; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); tick(); tick(); tick();       // E1, E2, sample 0, sample 1
    abort = 1'b1;
    tick();                               // sample 2 edge
    abort = 1'b0;
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_run_cycles", run_cycles_a, 13);
    tick();
    chk("abort_no_late_done", done_a, 0);

    // start with abort in IDLE: abort wins.
    start_a = 1'b1; abort = 1'b1;
    tick();
    start_a = 1'b0; abort = 1'b0;
    chk("sa_busy", busy_a, 0);
    chk("sa_cnt_reset", cnt_reset_a, 0);

    // Target 12: match at sample 7, crossing at sample 3.
    target = 4'd12; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); tick();
    wait_done_a(n);
    chk("t12_edges_to_done", n, 8);
    chk("t12_run_cycles", run_cycles_a, 7);
    chk("t12_cross_seen", cross_seen_a, XD ? 1 : 0);
    chk("t12_cross_at", cross_at_a, XD ? 3 : 0);
    tick();
    chk("t12_cross_held_idle", cross_seen_a, XD ? 1 : 0);

    // Reset in the middle of RUN clears every output at that edge.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick();
    start_a = 1'b1; reset = 1'b1;
    tick();
    start_a = 1'b0; reset = 1'b0;
    chk("mrst_busy", busy_a, 0);
    chk("mrst_cnt_reset", cnt_reset_a, 0);
    chk("mrst_cnt_load", cnt_load_a, 0);
    chk("mrst_done", done_a, 0);
    chk("mrst_timeout", timeout_a, 0);
    chk("mrst_run_cycles", run_cycles_a, 0);
    chk("mrst_cross_seen", cross_seen_a, 0);
    chk("mrst_cross_at", cross_at_a, 0);

    // MAX_CYCLES=4, target 15 unreachable: timeout after sample 3.
    target = 4'd15; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick(); tick();
    n = 0;
    while (done_b !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("to_edges_to_done", n, 4);
    chk("to_timeout", timeout_b, 1);
    chk("to_run_cycles", run_cycles_b, 4);
    tick();
    chk("to_timeout_pulse", timeout_b, 0);
    chk("to_done_pulse", done_b, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
